// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - descriptor-to-MIPS-word encoder that streams a session of instructions into IMEM
module instr_encoder #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  in_class,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_index,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        full,
  output logic        err,
  output logic [10:0] count
);

  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [9:0]  ptr;
  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        at_top;

  assign accept = in_valid && in_ready;
  assign at_top = (ptr == LAST_ADDR);

  always_comb begin
    legal = 1'b1;
    enc   = 32'h0000_0000;
    case (in_class)
      4'd0:  enc = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_op};
      4'd1:  enc = {6'b000010, in_index};
      4'd2:  enc = {6'b000011, in_index};
      4'd3:  enc = {6'b000000, in_rs, 15'b0, 6'b001000};
      4'd4:  enc = {6'b100000, in_rs, in_rt, in_imm};
      4'd5:  enc = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:  enc = {6'b101000, in_rs, in_rt, in_imm};
      4'd7:  enc = {6'b101011, in_rs, in_rt, in_imm};
      4'd8:  enc = {6'b000100, in_rs, in_rt, in_imm};
      4'd9:  enc = {6'b000101, in_rs, in_rt, in_imm};
      4'd10: begin
        // opcodes 0-7 collide with R/J/branch space and 32+ with memory ops
        enc   = {in_op, in_rs, in_rt, in_imm};
        legal = !((in_op[5:3] == 3'b000) || in_op[5]);
      end
      4'd11: enc = 32'h0000_0000;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 10'd0;
      imem_wdata <= 32'h0000_0000;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      count      <= 11'd0;
      ptr        <= 10'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            ptr      <= base_addr;
            count    <= 11'd0;
            done     <= 1'b0;
            full     <= 1'b0;
            err      <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc;
              count      <= count + 11'd1;
              // the pointer parks at the top word instead of wrapping
              if (at_top) full <= 1'b1;
              else        ptr  <= ptr + 10'd1;
            end else begin
              err <= 1'b1;
            end
            if (in_last || (legal && at_top)) begin
              state    <= DONE;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a session-level model
module tb_instr_encoder;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [3:0]  cls;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        last;
  } desc_t;

  logic        clk;
  logic        rst_n, start, in_valid, in_ready, in_last;
  logic [9:0]  base_addr;
  logic [3:0]  in_class;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_index;
  logic        imem_we, done, full, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] count;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_class(in_class), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_index(in_index),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .full(full), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          m_run, m_done, m_full, m_err;
  int          m_ptr, m_cnt;
  logic [9:0]  m_addr;
  logic [31:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint fld(input longint v, input int pos);
    return v * (longint'(1) << pos);
  endfunction

  function automatic logic [31:0] ref_enc(input desc_t d, output bit ok);
    int     op_tab [6] = '{32, 35, 40, 43, 4, 5};
    longint v = 0;
    int     c = int'(d.cls);
    ok = 1;
    if (c == 0)
      v = fld(d.rs, 21) + fld(d.rt, 16) + fld(d.rd, 11) + fld(d.sh, 6) + longint'(d.op);
    else if (c == 1 || c == 2)
      v = fld(c + 1, 26) + longint'(d.idx);
    else if (c == 3)
      v = fld(d.rs, 21) + 8;
    else if (c >= 4 && c <= 9)
      v = fld(op_tab[c-4], 26) + fld(d.rs, 21) + fld(d.rt, 16) + longint'(d.imm);
    else if (c == 10) begin
      v  = fld(d.op, 26) + fld(d.rs, 21) + fld(d.rt, 16) + longint'(d.imm);
      ok = (int'(d.op) >= 8) && (int'(d.op) < 32);
    end else if (c == 11)
      v = 0;
    else
      ok = 0;
    return v[31:0];
  endfunction

  function automatic desc_t mk(input int cls, input int op, input int rs, input int rt,
                               input int rd, input int imm, input int idx, input bit last);
    desc_t d;
    d.cls = 4'(cls); d.op = 6'(op); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd);
    d.sh = 5'd0; d.imm = 16'(imm); d.idx = 26'(idx); d.last = last;
    return d;
  endfunction

  function automatic desc_t rnd_desc();
    desc_t d;
    d.cls = 4'($urandom_range(0, 15)); d.op = 6'($urandom);
    d.rs = 5'($urandom); d.rt = 5'($urandom); d.rd = 5'($urandom); d.sh = 5'($urandom);
    d.imm = 16'($urandom); d.idx = 26'($urandom); d.last = ($urandom_range(0, 9) == 0);
    return d;
  endfunction

  task automatic check_all(input bit we_exp);
    check_eq("imem_we", 32'(imem_we), 32'(we_exp));
    check_eq("imem_addr", 32'(imem_addr), 32'(m_addr));
    check_eq("imem_wdata", imem_wdata, m_data);
    check_eq("count", 32'(count), 32'(m_cnt));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("full", 32'(full), 32'(m_full));
    check_eq("in_ready", 32'(in_ready), 32'(m_run));
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_full = 0; m_err = 0;
    m_ptr = 0; m_cnt = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic apply(input desc_t d);
    in_class = d.cls; in_op = d.op; in_rs = d.rs; in_rt = d.rt; in_rd = d.rd;
    in_shamt = d.sh; in_imm = d.imm; in_index = d.idx; in_last = d.last;
  endtask

  // called on a falling edge; applies one cycle of stimulus and checks after the next rising edge
  task automatic drive(input desc_t d, input bit v, input bit st, input int base);
    bit          acc, ok, we_exp;
    logic [31:0] e;
    apply(d);
    in_valid = v; start = st; base_addr = 10'(base);
    we_exp = 0;
    acc = v && m_run;
    if (acc) begin
      e = ref_enc(d, ok);
      if (ok) begin
        we_exp = 1; m_addr = 10'(m_ptr); m_data = e; m_cnt++;
        if (m_ptr == DEPTH - 1) begin m_full = 1; m_done = 1; m_run = 0; end
        else m_ptr++;
      end else m_err = 1;
      if (d.last) begin m_done = 1; m_run = 0; end
    end else if (st && !m_run) begin
      m_run = 1; m_ptr = base; m_cnt = 0; m_done = 0; m_full = 0; m_err = 0;
    end
    @(posedge clk); #1;
    check_all(we_exp);
    @(negedge clk);
    start = 0; in_valid = 0;
  endtask

  task automatic idle_cycle();
    drive(mk(11, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
  endtask

  task automatic begin_session(input int base);
    drive(mk(11, 0, 0, 0, 0, 0, 0, 0), 0, 1, base);
  endtask

  task automatic reset_mid_run();
    apply(mk(0, 6'h20, 1, 2, 3, 0, 0, 0));
    in_valid = 1; rst_n = 0;
    model_reset();
    #1;
    check_all(0);
    @(posedge clk); #1;
    check_all(0);
    @(negedge clk);
    in_valid = 0; rst_n = 1;
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = '0; in_valid = 0;
    apply(mk(11, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(negedge clk);
    check_all(0);
    rst_n = 1;
    @(negedge clk);
    idle_cycle();

    begin_session(10'h010);
    drive(mk(0, 6'h20, 1, 2, 3, 0, 0, 1), 1, 0, 0);
    check_eq("r_add_we", 32'(imem_we), 32'd1);
    check_eq("r_add_addr", 32'(imem_addr), 32'h010);
    check_eq("r_add_data", imem_wdata, 32'h0022_1820);
    idle_cycle();
    check_eq("r_add_done", 32'(done), 32'd1);
    check_eq("r_add_count", 32'(count), 32'd1);

    begin_session(10'h020);
    drive(mk(5, 0, 4, 5, 0, 16'h0008, 0, 0), 1, 0, 0);
    check_eq("lw_data", imem_wdata, 32'h8C85_0008);
    drive(mk(9, 0, 1, 2, 0, 16'hFFFE, 0, 0), 1, 0, 0);
    check_eq("bne_data", imem_wdata, 32'h1422_FFFE);
    drive(mk(2, 0, 0, 0, 0, 0, 26'h40, 1), 1, 0, 0);
    check_eq("jal_data", imem_wdata, 32'h0C00_0040);
    check_eq("jal_addr", 32'(imem_addr), 32'h022);

    begin_session(10'h040);
    drive(mk(10, 0, 1, 1, 0, 5, 0, 0), 1, 0, 0);
    drive(mk(13, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);
    drive(mk(3, 0, 31, 0, 0, 0, 0, 1), 1, 0, 0);
    check_eq("jr_data", imem_wdata, 32'h03E0_0008);
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_count", 32'(count), 32'd1);

    begin_session(10'h3FE);
    for (int i = 0; i < 3; i++) drive(mk(7, 0, 2, 3, 0, i, 0, 0), 1, 0, 0);
    check_eq("top_full", 32'(full), 32'd1);
    check_eq("top_ready", 32'(in_ready), 32'd0);
    check_eq("top_count", 32'(count), 32'd2);
    check_eq("top_addr", 32'(imem_addr), 32'h3FF);

    begin_session(10'h100);
    drive(mk(11, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0);
    drive(mk(1, 0, 0, 0, 0, 0, 26'h123, 0), 1, 1, 10'h200);
    drive(mk(11, 0, 0, 0, 0, 0, 0, 0), 0, 1, 10'h300);
    check_eq("start_in_run_count", 32'(count), 32'd2);
    check_eq("start_in_run_addr", 32'(imem_addr), 32'h101);
    reset_mid_run();
    idle_cycle();

    for (int s = 0; s < 40; s++) begin
      int base;
      base = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1012, 1023))
                                         : int'($urandom_range(0, 1023));
      begin_session(base);
      for (int k = 0; k < 30 && m_run; k++)
        drive(rnd_desc(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              int'($urandom_range(0, 1023)));
      if (m_run) drive(mk(11, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0);
      if ($urandom_range(0, 7) == 0) begin
        begin_session(int'($urandom_range(0, 1000)));
        drive(rnd_desc(), 1, 0, 0);
        reset_mid_run();
      end
      idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; parameter DEPTH, default 1024, is the IMEM depth in words.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a load session.
REQ-005 base_addr  input  10  first IMEM word address of the session.
REQ-006 in_valid  input  1  an instruction descriptor is present.
REQ-007 in_ready  output  1  encoder accepts a descriptor this cycle.
REQ-008 in_last  input  1  the descriptor is the final one of the session.
REQ-009 in_class  input  4  0 R, 1 J, 2 JAL, 3 JR, 4 LB, 5 LW, 6 SB, 7 SW, 8 BEQ, 9 BNE, 10 IMM, 11 NOP, 12-15 illegal.
REQ-010 in_op  input  6  funct for R; opcode for IMM; ignored otherwise.
REQ-011 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-012 in_imm  input  16  immediate or branch offset.
REQ-013 in_index  input  26  jump target index.
REQ-014 imem_we  output  1  IMEM write strobe.
REQ-015 imem_addr  output  10  IMEM word address.
REQ-016 imem_wdata  output  32  encoded instruction.
REQ-017 done  output  1  session complete.
REQ-018 full  output  1  session ended because address DEPTH-1 was written.
REQ-019 err  output  1  sticky flag: at least one illegal descriptor was dropped.
REQ-020 count  output  11  number of words written in the current session.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, and DONE; in_ready SHALL be 1 only in RUN.
REQ-022 IDLE or DONE with start=1 SHALL go to RUN next cycle, loading the write pointer from base_addr and clearing count, done, full, and err.
REQ-023 A descriptor SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-024 An accepted legal descriptor SHALL produce imem_we=1 for exactly the next cycle, with imem_addr equal to the pointer and imem_wdata equal to the encoding; the latency is 1 cycle.
REQ-025 After each write, the pointer and count SHALL each increment by 1.
REQ-026 Encoding of R: {000000, rs, rt, rd, shamt, in_op}.
REQ-027 Encoding of JR: {000000, rs, 15'b0, 001000}.
REQ-028 Encoding of J: {000010, index}; encoding of JAL: {000011, index}.
REQ-029 Opcodes for the {op, rs, rt, imm} encodings: LB 100000, LW 100011, SB 101000, SW 101011, BEQ 000100, BNE 000101.
REQ-030 Encoding of IMM: {in_op, rs, rt, imm}; encoding of NOP: 32'h0000_0000.
REQ-031 A descriptor SHALL be illegal if in_class>=12, or if in_class=10 and (in_op[5:3]=000 or in_op[5]=1).
REQ-032 An illegal descriptor SHALL be consumed but not written; it SHALL set err, leave the pointer and count unchanged, and keep the FSM in RUN.
REQ-033 An accepted descriptor with in_last=1 SHALL move the FSM to DONE; this applies even if the descriptor is illegal.
REQ-034 A legal write to address DEPTH-1 SHALL move the FSM to DONE and set full, with in_ready=0 from the next cycle; in_last on that descriptor SHALL give the same result.
REQ-035 The write pointer SHALL never wrap to 0.
REQ-036 done SHALL be held at 1 throughout DONE.
REQ-037 start during RUN SHALL be ignored.
REQ-038 imem_we SHALL be 0 whenever no write is issued; imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-039 On rst_n=0, immediately: state IDLE; in_ready, imem_we, done, full, and err all 0; imem_addr 0; imem_wdata 0; count 0; pointer 0.
REQ-040 Reset during RUN SHALL abandon the session, and no pending write SHALL be issued after reset is asserted.
REQ-041 After reset is released, the block SHALL wait in IDLE for start.

Verification
REQ-042 start with base_addr=0x010, then R add (rs=1, rt=2, rd=3, in_op=0x20) with in_last=1 -> the next cycle shows imem_we=1, imem_addr=0x010, imem_wdata=0x00221820; then done=1 and count=1.
REQ-043 LW rs=4 rt=5 imm=0x0008, then BNE rs=1 rt=2 imm=0xFFFE, then JAL index=0x0000040 -> writes 0x8C850008, 0x1422FFFE, 0x0C000040 at consecutive addresses.
REQ-044 IMM with in_op=0x00, then class 13, then JR rs=31 -> err=1; only 0x03E00008 is written; count=1.
REQ-045 base_addr=0x3FE, three SW descriptors without in_last -> two writes at 0x3FE and 0x3FF, then full=1, done=1, in_ready=0; the third descriptor is not accepted.
REQ-046 Hold in_valid=1 and assert rst_n=0 during RUN in the same cycle as an acceptance -> imem_we stays 0 and all outputs show their reset values.
REQ-047 start pulse while in RUN -> no effect on the pointer or count.
